// File: rtl/obc_shift_accum.sv
// OBC shift-accumulator: weights NBITS bit-slice partial sums, adds the offset, and emits one DFT bin component.
// Optional feature: define OBC_SAT_EN to saturate the result to OUT_W bits instead of wrapping.
module obc_shift_accum #(
    parameter int unsigned              NBITS  = 16,
    parameter int unsigned              IN_W   = 32,
    parameter int unsigned              ACC_W  = 48,
    parameter int unsigned              OUT_W  = 40,
    parameter logic signed [ACC_W-1:0]  OFFSET = '0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [IN_W-1:0]                                in_data,
    output logic [((NBITS > 1) ? $clog2(NBITS) : 1)-1:0]   slice_idx,
    output logic                                           m_out,
    output logic                                           busy,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [OUT_W-1:0]                               out_data
);

    localparam int unsigned         IDX_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NBITS - 1);
    localparam logic [ACC_W-1:0]    OFFSET_U = OFFSET;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               busy_nxt;
    logic               ov_nxt;
    logic [OUT_W-1:0]   od_nxt;

    logic               in_fire;
    logic               out_fire;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   fin;
    logic [OUT_W-1:0]   res_fmt;

    // Weighted slice; the first slice of a transform starts from zero, not the stale accumulator
    always_comb begin
        in_ext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
        sum    = ((state == ACCUM) ? acc : '0) + (in_ext << slice_idx);
        fin    = sum + OFFSET_U;
    end

`ifdef OBC_SAT_EN
    logic [ACC_W-OUT_W:0] fin_hi;

    // Value fits when every bit above the OUT_W sign bit matches it
    always_comb begin
        fin_hi  = fin[ACC_W-1:OUT_W-1];
        res_fmt = OUT_W'(fin);
        if (!((&fin_hi) || (~|fin_hi))) begin
            res_fmt = fin[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    always_comb res_fmt = OUT_W'(fin);
`endif

    always_comb begin
        in_ready = (state == HOLD) ? out_ready : 1'b1;
        m_out    = (slice_idx == LAST_IDX);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            slice_idx <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            slice_idx <= idx_nxt;
            busy      <= busy_nxt;
            out_valid <= ov_nxt;
            out_data  <= od_nxt;
        end
    end

    // A slice accepted in HOLD coincides with the output transfer and overrides the return to IDLE
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = slice_idx;
        busy_nxt  = busy;
        ov_nxt    = out_valid;
        od_nxt    = out_data;

        if ((state == HOLD) && out_fire) begin
            ov_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
        end

        if (in_fire) begin
            busy_nxt = 1'b1;
            if (slice_idx == LAST_IDX) begin
                od_nxt    = res_fmt;
                ov_nxt    = 1'b1;
                idx_nxt   = '0;
                state_nxt = HOLD;
            end else begin
                acc_nxt   = sum;
                idx_nxt   = IDX_W'(slice_idx + 1'b1);
                state_nxt = ACCUM;
            end
        end
    end

endmodule
